// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution window engine.
package conv_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 8;
    localparam int WIN_W  = 200;
    localparam int ACC_W  = 22;

    localparam logic [1:0] SZ_2X2 = 2'd0;
    localparam logic [1:0] SZ_3X3 = 2'd1;
    localparam logic [1:0] SZ_INV = 2'd2;
    localparam logic [1:0] SZ_5X5 = 2'd3;

    typedef enum logic [1:0] {IDLE, CAPTURE, MAC, OUT} state_e;

    function automatic logic [2:0] rows_of(input logic [1:0] sz);
        case (sz)
            SZ_2X2:  return 3'd2;
            SZ_3X3:  return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

endpackage

// File: rtl/conv_window_engine_if.sv
// Pixel write-back handshake between the engine and its consumer.
interface conv_window_engine_if;
    import conv_pkg::*;

    logic [PIX_W-1:0] pix_out;
    logic             pix_valid;
    logic             pix_ready;

    modport master (output pix_out, output pix_valid, input pix_ready);
    modport slave  (input pix_out, input pix_valid, output pix_ready);

endinterface

// File: rtl/conv_window_engine_row_mac.sv
// One kernel row: 5 unsigned pixels dotted with 5 signed coefficients.
module conv_row_mac
    import conv_pkg::*;
(
    input  logic [5*PIX_W-1:0]      pix,
    input  logic [5*COEF_W-1:0]     coef,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [PIX_W:0]    px_s;
    logic signed [COEF_W-1:0] cf_s;
    logic signed [ACC_W-1:0]  px_x;
    logic signed [ACC_W-1:0]  cf_x;

    always_comb begin
        sum  = '0;
        px_s = '0;
        cf_s = '0;
        px_x = '0;
        cf_x = '0;
        for (int c = 0; c < 5; c++) begin
            px_s = $signed({1'b0, pix[c*PIX_W +: PIX_W]});
            cf_s = $signed(coef[c*COEF_W +: COEF_W]);
            px_x = ACC_W'(px_s);
            cf_x = ACC_W'(cf_s);
            sum  = sum + px_x * cf_x;
        end
    end

endmodule

// File: rtl/conv_window_engine.sv
// Per-column window capture, row-serial convolution, saturation and
// valid/ready write-back for one line per start.
module conv_window_engine
    import conv_pkg::*;
#(
    parameter int LINE_W = 512,
    localparam int COL_W = $clog2(LINE_W)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           size,
    input  logic [WIN_W-1:0]     kernel,
    input  logic [3:0]           shift,
    input  logic [WIN_W-1:0]     matrix,
    output logic                 next_matrix,
    output logic [COL_W-1:0]     col_addr,
    output logic                 busy,
    output logic                 line_done,
    output logic                 cfg_err,
    conv_window_engine_if.master pix_if
);

    state_e                  state_q, state_d;
    logic [2:0]              rows_q, rows_d;
    logic [2:0]              row_q, row_d;
    logic [WIN_W-1:0]        kern_q, kern_d;
    logic [WIN_W-1:0]        win_q, win_d;
    logic [3:0]              shift_q, shift_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [PIX_W-1:0]        pix_q, pix_d;
    logic                    valid_q, valid_d;
    logic                    nm_q, nm_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [5*PIX_W-1:0]      row_pix;
    logic [5*COEF_W-1:0]     row_coef;
    logic signed [ACC_W-1:0] row_sum;
    logic signed [ACC_W-1:0] total;
    logic signed [ACC_W-1:0] res;
    logic [PIX_W-1:0]        sat;

    always_comb begin
        row_pix  = '0;
        row_coef = '0;
        for (int r = 0; r < 5; r++) begin
            if (row_q == 3'(r)) begin
                row_pix  = win_q[r*5*PIX_W +: 5*PIX_W];
                row_coef = kern_q[r*5*COEF_W +: 5*COEF_W];
            end
        end
    end

    conv_row_mac u_row_mac (
        .pix  (row_pix),
        .coef (row_coef),
        .sum  (row_sum)
    );

    // Last row is folded in combinationally so the pixel lands in OUT directly.
    assign total = acc_q + row_sum;
    assign res   = total >>> shift_q;

    always_comb begin
        if (res[ACC_W-1])
            sat = '0;
        else if (|res[ACC_W-2:PIX_W])
            sat = '1;
        else
            sat = res[PIX_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        row_d   = row_q;
        kern_d  = kern_q;
        win_d   = win_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        col_d   = col_q;
        pix_d   = pix_q;
        valid_d = valid_q;
        err_d   = err_q;
        nm_d    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (size == SZ_INV) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        rows_d  = rows_of(size);
                        kern_d  = kernel;
                        shift_d = shift;
                        col_d   = '0;
                        nm_d    = 1'b1;
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                win_d   = matrix;
                acc_d   = '0;
                row_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                if (row_q == rows_q - 3'd1) begin
                    pix_d   = sat;
                    valid_d = 1'b1;
                    state_d = OUT;
                end else begin
                    acc_d = total;
                    row_d = row_q + 3'd1;
                end
            end
            OUT: begin
                if (valid_q && pix_if.pix_ready) begin
                    valid_d = 1'b0;
                    if (col_q == COL_W'(LINE_W - 1)) begin
                        col_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        nm_d    = 1'b1;
                        state_d = CAPTURE;
                    end
                end
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rows_q  <= 3'd3;
            row_q   <= '0;
            kern_q  <= '0;
            win_q   <= '0;
            shift_q <= '0;
            acc_q   <= '0;
            col_q   <= '0;
            pix_q   <= '0;
            valid_q <= 1'b0;
            nm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            row_q   <= row_d;
            kern_q  <= kern_d;
            win_q   <= win_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            col_q   <= col_d;
            pix_q   <= pix_d;
            valid_q <= valid_d;
            nm_q    <= nm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign next_matrix      = nm_q;
    assign col_addr         = col_q;
    assign busy             = busy_q;
    assign line_done        = done_q;
    assign cfg_err          = err_q;
    assign pix_if.pix_out   = pix_q;
    assign pix_if.pix_valid = valid_q;

endmodule

// File: tb/tb_conv_window_engine.sv
// Scoreboard bench: windows are modelled as N x N pixel grids and the
// expected pixel is computed with plain integer arithmetic.
module tb_conv_window_engine;
    import conv_pkg::*;

    localparam int MD_RAND = 0;
    localparam int MD_IDEN = 1;
    localparam int MD_BOX  = 2;
    localparam int MD_LAP  = 3;
    localparam int MD_ONE5 = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   size = 2'd1;
    logic [199:0] kernel = '0;
    logic [3:0]   shift = '0;
    logic [199:0] matrix = '0;
    logic         next_matrix;
    logic [8:0]   col_addr;
    logic         busy;
    logic         line_done;
    logic         cfg_err;

    conv_window_engine_if pif ();

    conv_window_engine #(.LINE_W(512)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size        (size),
        .kernel      (kernel),
        .shift       (shift),
        .matrix      (matrix),
        .next_matrix (next_matrix),
        .col_addr    (col_addr),
        .busy        (busy),
        .line_done   (line_done),
        .cfg_err     (cfg_err),
        .pix_if      (pif.master)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           passed = 0;
    int           gmode = MD_RAND;
    int           n_cur = 3;
    int           sh_cur = 0;
    logic [199:0] k_cur = '0;
    int           rdy_mode = 0;
    bit           chk_period = 1'b0;
    bit           have_prev = 1'b0;
    int           nm_cnt = 0;
    int           done_cnt = 0;
    int           cyc = 0;
    int           prev_nm = 0;
    bit           valid_prev = 1'b0;
    logic [7:0]   expq[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic logic [7:0] model(input logic [199:0] m,
                                         input logic [199:0] k,
                                         input int n, input int sh);
        int s = 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                s += int'(m[(r*5+c)*8 +: 8]) *
                     int'($signed(k[(r*5+c)*8 +: 8]));
        s = s >>> sh;
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    function automatic logic [199:0] gen(input int md, input int n);
        logic [199:0] m = '0;
        bit           b = 1'($urandom_range(0, 1));
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                logic [7:0] v;
                v = 8'($urandom_range(0, 255));
                case (md)
                    MD_IDEN: if (r == 1 && c == 1) v = 8'h5A;
                    MD_BOX:  v = 8'd200;
                    MD_LAP:  v = ((r == 1 && c == 1) == b) ? 8'd255 : 8'd0;
                    MD_ONE5: v = 8'd10;
                    default: ;
                endcase
                m[(r*5+c)*8 +: 8] = v;
            end
        return m;
    endfunction

    function automatic logic [199:0] ker(input int md);
        logic [199:0] k = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                logic [7:0] v;
                bit         in3 = (r < 3 && c < 3);
                bit         ctr = (r == 1 && c == 1);
                case (md)
                    MD_IDEN: v = ctr ? 8'd1 : 8'd0;
                    MD_BOX:  v = in3 ? 8'd1 : 8'd0;
                    MD_LAP:  v = ctr ? 8'd8 : (in3 ? 8'hFF : 8'd0);
                    MD_ONE5: v = 8'd1;
                    default: v = 8'($urandom_range(0, 255));
                endcase
                k[(r*5+c)*8 +: 8] = v;
            end
        return k;
    endfunction

    // Window source: hold the window while next_matrix is up, else refresh.
    always @(negedge clk) begin
        if (rst_n) begin
            if (next_matrix)
                expq.push_back(model(matrix, k_cur, n_cur, sh_cur));
            else
                matrix = gen(gmode, n_cur);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) pif.pix_ready = 1'b1;
        else if (rdy_mode == 1) pif.pix_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: scoreboard pops, next_matrix spacing and valid latency.
    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
            have_prev  = 1'b0;
        end else begin
            cyc++;
            if (pif.pix_valid && pif.pix_ready) begin
                if (expq.size() == 0) chk("pix_unexpected", 1, 0);
                else chk("pix_out", int'(pif.pix_out), int'(expq.pop_front()));
            end
            if (next_matrix) begin
                if (chk_period && have_prev)
                    chk("nm_period", cyc - prev_nm, n_cur + 2);
                prev_nm   = cyc;
                have_prev = 1'b1;
                nm_cnt++;
            end
            if (pif.pix_valid && !valid_prev && have_prev)
                chk("valid_latency", cyc - prev_nm, n_cur + 1);
            valid_prev = pif.pix_valid;
            if (line_done) done_cnt++;
        end
    end

    task automatic start_line(input int md, input logic [1:0] sz,
                              input int sh, input int rm, input bit per);
        gmode      = md;
        n_cur      = (sz == SZ_2X2) ? 2 : (sz == SZ_3X3) ? 3 : 5;
        k_cur      = ker(md);
        sh_cur     = sh;
        kernel     = k_cur;
        shift      = 4'(sh);
        size       = sz;
        rdy_mode   = rm;
        chk_period = per;
        have_prev  = 1'b0;
        nm_cnt     = 0;
        done_cnt   = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic finish_line(input string tag);
        for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk({tag, "_line_done"}, done_cnt, 1);
        chk({tag, "_nm_pulses"}, nm_cnt, 512);
        chk({tag, "_queue_left"}, expq.size(), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_col"}, int'(col_addr), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    endtask

    task automatic wait_col_capture(input int col, output bit found);
        found = 1'b0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            if (next_matrix && int'(col_addr) == col) found = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_next_matrix"}, int'(next_matrix), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_line_done"}, int'(line_done), 0);
        chk({tag, "_cfg_err"}, int'(cfg_err), 0);
        chk({tag, "_col"}, int'(col_addr), 0);
        chk({tag, "_pix_valid"}, int'(pif.pix_valid), 0);
        chk({tag, "_pix_out"}, int'(pif.pix_out), 0);
    endtask

    initial begin
        bit         found;
        logic [7:0] hold_pix;
        int         hold_col;

        pif.pix_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        start_line(MD_IDEN, SZ_3X3, 0, 0, 1'b1);
        finish_line("identity");

        start_line(MD_BOX, SZ_3X3, 3, 0, 1'b0);
        wait_col_capture(50, found);
        chk("bp_found_col50", int'(found), 1);
        rdy_mode = 2;
        pif.pix_ready = 1'b0;
        for (int i = 0; i < 20 && !pif.pix_valid; i++) @(negedge clk);
        chk("bp_valid_up", int'(pif.pix_valid), 1);
        hold_pix = pif.pix_out;
        hold_col = int'(col_addr);
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_held", int'(pif.pix_valid), 1);
            chk("bp_pix_held", int'(pif.pix_out), int'(hold_pix));
            chk("bp_no_next_matrix", int'(next_matrix), 0);
            chk("bp_col_held", int'(col_addr), hold_col);
        end
        @(posedge clk);
        #1;
        pif.pix_ready = 1'b1;
        rdy_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_col_step", int'(col_addr), hold_col + 1);
        finish_line("box");

        start_line(MD_LAP, SZ_3X3, 0, 1, 1'b0);
        finish_line("laplacian");

        start_line(MD_ONE5, SZ_5X5, 0, 0, 1'b1);
        finish_line("ones5x5");

        start_line(MD_RAND, SZ_2X2, $urandom_range(0, 4), 1, 1'b0);
        finish_line("rand2x2");

        start_line(MD_RAND, SZ_3X3, $urandom_range(0, 8), 1, 1'b0);
        finish_line("rand3x3");

        start_line(MD_RAND, SZ_3X3, 2, 0, 1'b0);
        wait_col_capture(100, found);
        chk("rst_found_col100", int'(found), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        expq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_busy", int'(busy), 0);
        chk("postrst_valid", int'(pif.pix_valid), 0);

        @(negedge clk);
        size  = SZ_INV;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err_set", int'(cfg_err), 1);
        chk("cfg_err_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("cfg_err_sticky", int'(cfg_err), 1);
        chk("cfg_err_idle", int'(busy), 0);

        start_line(MD_RAND, SZ_5X5, $urandom_range(0, 10), 1, 1'b0);
        finish_line("rand5x5");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
